// File: rtl/process_scheduler_pkg.sv
// Shared types and defaults for the process scheduler.
package process_scheduler_pkg;

    localparam int unsigned DefaultNproc   = 8;
    localparam int unsigned DefaultQuantum = 16;

    typedef enum logic [1:0] {
        SlotFree    = 2'd0,
        SlotReady   = 2'd1,
        SlotRunning = 2'd2,
        SlotBlocked = 2'd3
    } slot_status_e;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StSelect,
        StLoad
    } sched_state_e;

endpackage

// File: rtl/process_scheduler_rr_select.sv
// Combinational round-robin search: first set bit of ready_mask at or after start, wrapping.
module rr_select #(
    parameter int unsigned N    = 8,
    parameter int unsigned IdxW = $clog2(N)
) (
    input  logic [N-1:0]    ready_mask,
    input  logic [IdxW-1:0] start,
    output logic            found,
    output logic [IdxW-1:0] index
);

    logic [IdxW:0]   sum;
    logic [IdxW-1:0] idx;

    // Walk from the farthest offset down so the nearest ready slot is the last one written.
    always_comb begin
        found = 1'b0;
        index = '0;
        sum   = '0;
        idx   = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            sum = {1'b0, start} + (IdxW + 1)'(i);
            if (sum >= (IdxW + 1)'(N)) begin
                sum = sum - (IdxW + 1)'(N);
            end
            idx = sum[IdxW-1:0];
            if (ready_mask[idx]) begin
                found = 1'b1;
                index = idx;
            end
        end
    end

endmodule

// File: rtl/process_scheduler.sv
// Round-robin process scheduler with IO blocking; time-slice preemption enabled by SCHED_PREEMPT_EN.
module process_scheduler
    import process_scheduler_pkg::*;
#(
    parameter int unsigned NPROC   = DefaultNproc,
    parameter int unsigned PC_W    = 32,
    parameter int unsigned QUANTUM = DefaultQuantum
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     proc_create,
    input  logic [$clog2(NPROC)-1:0] create_id,
    input  logic [PC_W-1:0]          create_pc,
    input  logic                     instr_valid,
    input  logic [PC_W-1:0]          resume_pc,
    input  logic                     io_req,
    input  logic                     io_done,
    input  logic [$clog2(NPROC)-1:0] io_done_id,
    input  logic                     proc_exit,
    output logic                     switch_req,
    output logic [PC_W-1:0]          next_pc,
    output logic [$clog2(NPROC)-1:0] cur_pid,
    output logic                     running,
    output logic                     idle,
    output logic                     create_err
);

    localparam int unsigned IdW = $clog2(NPROC);

    sched_state_e    state_q, state_d;
    slot_status_e    status_q [NPROC];
    slot_status_e    status_d [NPROC];
    logic [PC_W-1:0] pc_q [NPROC];
    logic [PC_W-1:0] pc_d [NPROC];
    logic [IdW-1:0]  cur_pid_q, cur_pid_d;
    logic [PC_W-1:0] next_pc_q, next_pc_d;
    logic            create_err_q, create_err_d;

    logic [NPROC-1:0] ready_mask;
    logic [IdW-1:0]   search_start;
    logic             sel_found;
    logic [IdW-1:0]   sel_idx;
    logic             expire;

`ifdef SCHED_PREEMPT_EN
    localparam int unsigned QW = $clog2(QUANTUM);
    logic [QW-1:0] quantum_q, quantum_d;
    assign expire = instr_valid && (quantum_q == QW'(QUANTUM - 1));
`else
    localparam int unsigned unused_quantum = QUANTUM;
    logic unused_instr;
    assign unused_instr = instr_valid;
    assign expire       = 1'b0;
`endif

    always_comb begin
        for (int i = 0; i < int'(NPROC); i++) begin
            ready_mask[i] = (status_q[i] == SlotReady);
        end
    end

    // Start one past the current slot so the current slot is considered last.
    assign search_start = (cur_pid_q == IdW'(NPROC - 1)) ? '0 : cur_pid_q + 1'b1;

    rr_select #(
        .N    (NPROC),
        .IdxW (IdW)
    ) u_rr_select (
        .ready_mask (ready_mask),
        .start      (search_start),
        .found      (sel_found),
        .index      (sel_idx)
    );

    always_comb begin
        state_d   = state_q;
        status_d  = status_q;
        pc_d      = pc_q;
        cur_pid_d = cur_pid_q;
        next_pc_d = next_pc_q;
`ifdef SCHED_PREEMPT_EN
        quantum_d = quantum_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (|ready_mask) state_d = StSelect;
            end
            StRun: begin
`ifdef SCHED_PREEMPT_EN
                if (instr_valid) quantum_d = quantum_q + 1'b1;
`endif
                if (proc_exit) begin
                    status_d[cur_pid_q] = SlotFree;
                    state_d             = StSelect;
                end else if (io_req) begin
                    pc_d[cur_pid_q]     = resume_pc;
                    status_d[cur_pid_q] = SlotBlocked;
                    state_d             = StSelect;
                end else if (expire) begin
                    pc_d[cur_pid_q]     = resume_pc;
                    status_d[cur_pid_q] = SlotReady;
                    state_d             = StSelect;
                end
            end
            StSelect: begin
                if (sel_found) begin
                    cur_pid_d = sel_idx;
                    next_pc_d = pc_q[sel_idx];
                    state_d   = StLoad;
                end else begin
                    state_d = StIdle;
                end
            end
            StLoad: begin
                status_d[cur_pid_q] = SlotRunning;
`ifdef SCHED_PREEMPT_EN
                quantum_d = '0;
`endif
                state_d = StRun;
            end
            default: state_d = StIdle;
        endcase

        // Create targets a FREE slot and io_done a BLOCKED one, so neither can collide with
        // the running slot's update above or with each other.
        create_err_d = 1'b0;
        if (proc_create) begin
            if (status_q[create_id] == SlotFree) begin
                status_d[create_id] = SlotReady;
                pc_d[create_id]     = create_pc;
            end else begin
                create_err_d = 1'b1;
            end
        end
        if (io_done && status_q[io_done_id] == SlotBlocked) begin
            status_d[io_done_id] = SlotReady;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= StIdle;
            cur_pid_q    <= '0;
            next_pc_q    <= '0;
            create_err_q <= 1'b0;
            for (int i = 0; i < int'(NPROC); i++) begin
                status_q[i] <= SlotFree;
                pc_q[i]     <= '0;
            end
`ifdef SCHED_PREEMPT_EN
            quantum_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cur_pid_q    <= cur_pid_d;
            next_pc_q    <= next_pc_d;
            create_err_q <= create_err_d;
            status_q     <= status_d;
            pc_q         <= pc_d;
`ifdef SCHED_PREEMPT_EN
            quantum_q <= quantum_d;
`endif
        end
    end

    assign switch_req = (state_q == StLoad);
    assign running    = (state_q == StRun);
    assign idle       = (state_q == StIdle);
    assign next_pc    = next_pc_q;
    assign cur_pid    = cur_pid_q;
    assign create_err = create_err_q;

endmodule

// File: tb/tb_process_scheduler.sv
// Directed self-checking bench for process_scheduler; follows SCHED_PREEMPT_EN when defined.
module tb_process_scheduler;

    localparam int unsigned NPROC   = 8;
    localparam int unsigned PC_W    = 32;
    localparam int unsigned QUANTUM = 16;

    logic            clock;
    logic            reset;
    logic            proc_create;
    logic [2:0]      create_id;
    logic [PC_W-1:0] create_pc;
    logic            instr_valid;
    logic [PC_W-1:0] resume_pc;
    logic            io_req;
    logic            io_done;
    logic [2:0]      io_done_id;
    logic            proc_exit;
    logic            switch_req;
    logic [PC_W-1:0] next_pc;
    logic [2:0]      cur_pid;
    logic            running;
    logic            idle;
    logic            create_err;

    int n_vec = 0;
    int n_bad = 0;

    process_scheduler #(
        .NPROC   (NPROC),
        .PC_W    (PC_W),
        .QUANTUM (QUANTUM)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .proc_create (proc_create),
        .create_id   (create_id),
        .create_pc   (create_pc),
        .instr_valid (instr_valid),
        .resume_pc   (resume_pc),
        .io_req      (io_req),
        .io_done     (io_done),
        .io_done_id  (io_done_id),
        .proc_exit   (proc_exit),
        .switch_req  (switch_req),
        .next_pc     (next_pc),
        .cur_pid     (cur_pid),
        .running     (running),
        .idle        (idle),
        .create_err  (create_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        proc_create = 1'b0;
        create_id   = '0;
        create_pc   = '0;
        instr_valid = 1'b0;
        resume_pc   = '0;
        io_req      = 1'b0;
        io_done     = 1'b0;
        io_done_id  = '0;
        proc_exit   = 1'b0;
    endtask

    task automatic do_create(input logic [2:0] id, input logic [PC_W-1:0] pc);
        proc_create = 1'b1;
        create_id   = id;
        create_pc   = pc;
        tick();
        proc_create = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        proc_create = 1'b1;
        tick();
        tick();
        clear_inputs();
        check_eq("rst_running", running, 0);
        check_eq("rst_idle", idle, 1);
        check_eq("rst_switch", switch_req, 0);
        check_eq("rst_cur_pid", cur_pid, 0);
        check_eq("rst_next_pc", next_pc, 0);
        check_eq("rst_create_err", create_err, 0);

        // First process from idle: IDLE -> SELECT -> LOAD -> RUN.
        reset = 1'b1;
        do_create(3'd0, 32'h100);
        check_eq("idle_after_create", idle, 1);
        tick();
        check_eq("select_not_idle", idle, 0);
        check_eq("select_no_switch", switch_req, 0);
        tick();
        check_eq("load0_switch", switch_req, 1);
        check_eq("load0_next_pc", next_pc, 32'h100);
        check_eq("load0_cur_pid", cur_pid, 0);
        tick();
        check_eq("run0_running", running, 1);
        check_eq("run0_switch_low", switch_req, 0);

        do_create(3'd3, 32'h200);
        check_eq("create3_no_err", create_err, 0);

`ifdef SCHED_PREEMPT_EN
        // Gaps between retirements must not count toward the slice.
        for (int i = 0; i < int'(QUANTUM); i++) begin
            instr_valid = 1'b1;
            resume_pc   = 32'h101 + i;
            tick();
            instr_valid = 1'b0;
            if (i < int'(QUANTUM) - 1) begin
                tick();
                if (i == int'(QUANTUM) - 2) check_eq("quantum_minus1_running", running, 1);
            end
        end
        check_eq("expire_select", running, 0);
        tick();
`else
        for (int i = 0; i < 20; i++) begin
            instr_valid = 1'b1;
            tick();
        end
        instr_valid = 1'b0;
        check_eq("no_preempt_running", running, 1);
        check_eq("no_preempt_switch", switch_req, 0);
        io_req    = 1'b1;
        resume_pc = 32'h110;
        tick();
        io_req     = 1'b0;
        io_done    = 1'b1;
        io_done_id = 3'd0;
        check_eq("io0_select", running, 0);
        tick();
        io_done = 1'b0;
`endif
        check_eq("sw3_switch", switch_req, 1);
        check_eq("sw3_cur_pid", cur_pid, 3);
        check_eq("sw3_next_pc", next_pc, 32'h200);
        tick();
        check_eq("run3_running", running, 1);

        // Block slot 3; slot 0 resumes at its saved PC.
        io_req    = 1'b1;
        resume_pc = 32'h205;
        tick();
        clear_inputs();
        check_eq("io3_select", running, 0);
        tick();
        check_eq("sw0_switch", switch_req, 1);
        check_eq("sw0_cur_pid", cur_pid, 0);
        check_eq("sw0_next_pc", next_pc, 32'h110);
        tick();
        io_done    = 1'b1;
        io_done_id = 3'd3;
        tick();
        clear_inputs();
        check_eq("io_done_running", running, 1);

        // Exit and IO in the same cycle: exit wins, slot 0 freed, slot 3 resumes.
        proc_exit = 1'b1;
        io_req    = 1'b1;
        resume_pc = 32'h999;
        tick();
        clear_inputs();
        tick();
        check_eq("exitwin_switch", switch_req, 1);
        check_eq("exitwin_cur_pid", cur_pid, 3);
        check_eq("exitwin_next_pc", next_pc, 32'h205);
        tick();

        do_create(3'd0, 32'h300);
        check_eq("recreate0_no_err", create_err, 0);
        do_create(3'd0, 32'h777);
        check_eq("dup_create_err", create_err, 1);
        tick();
        check_eq("create_err_pulse", create_err, 0);

        io_req    = 1'b1;
        resume_pc = 32'h210;
        tick();
        clear_inputs();
        tick();
        check_eq("sw0b_cur_pid", cur_pid, 0);
        check_eq("sw0b_next_pc", next_pc, 32'h300);
        tick();

        // Last live process exits: SELECT then IDLE without a switch.
        proc_exit = 1'b1;
        tick();
        clear_inputs();
        check_eq("lastexit_select", idle, 0);
        tick();
        check_eq("lastexit_idle", idle, 1);
        check_eq("lastexit_no_switch", switch_req, 0);
        tick();
        check_eq("lastexit_stay_idle", idle, 1);

        do_create(3'd5, 32'h500);
        tick();
        tick();
        check_eq("sw5_switch", switch_req, 1);
        check_eq("sw5_cur_pid", cur_pid, 5);
        check_eq("sw5_next_pc", next_pc, 32'h500);
        tick();

        // io_done for the slot blocking in the same cycle is ignored.
        io_req     = 1'b1;
        resume_pc  = 32'h510;
        io_done    = 1'b1;
        io_done_id = 3'd5;
        tick();
        clear_inputs();
        tick();
        check_eq("selfdone_idle", idle, 1);
        check_eq("selfdone_no_switch", switch_req, 0);

        // Reset during SELECT aborts the pending switch.
        io_done    = 1'b1;
        io_done_id = 3'd3;
        tick();
        clear_inputs();
        tick();
        check_eq("pre_reset_select", idle, 0);
        reset = 1'b0;
        tick();
        check_eq("abort_switch", switch_req, 0);
        check_eq("abort_idle", idle, 1);
        check_eq("abort_running", running, 0);
        check_eq("abort_cur_pid", cur_pid, 0);
        check_eq("abort_next_pc", next_pc, 0);
        check_eq("abort_create_err", create_err, 0);
        reset = 1'b1;
        tick();
        check_eq("post_reset_idle", idle, 1);
        tick();
        check_eq("post_reset_no_switch", switch_req, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
